// File: rtl/cpu_run_pkg.sv
// Shared encodings for the CPU run/halt/step sequencer: FSM states,
// rate-select codes and the CPU phase-counter width.
package cpu_run_pkg;

    localparam int PHASE_W = 3;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_STEP  = 2'd3
    } runState_t;

    localparam logic [1:0] RATE_MANUAL = 2'b00;
    localparam logic [1:0] RATE_SLOW   = 2'b01;
    localparam logic [1:0] RATE_FAST   = 2'b10;
    localparam logic [1:0] RATE_FULL   = 2'b11;

    // Phase the next enable will execute, given the phase counter and
    // whether an enable is live in the current clk.
    function automatic logic [PHASE_W-1:0] nextPhase(
        input logic [PHASE_W-1:0] cycle,
        input logic               en
    );
        return cycle + {{(PHASE_W-1){1'b0}}, en};
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Control bundle between the front end / CPU core and the run sequencer.
// runReq and haltReq are one-clk pulses with no ready: sampled every clk and
// dropped if not accepted; stepBtn is a level whose rising edge counts.
interface cpu_run_ctrl_if
    import cpu_run_pkg::*;
#(
    parameter int ADDR_W = 12
);

    logic [1:0]         rateSel;
    logic               stepBtn;
    logic               stepInstr;
    logic               runReq;
    logic               haltReq;
    logic               bpEn;
    logic [ADDR_W-1:0]  bpAddr;
    logic [ADDR_W-1:0]  pcAddr;
    logic [PHASE_W-1:0] cycle;

    logic               cpuEn;
    logic [1:0]         state;
    logic               halted;
    logic               bpHit;

    modport master (
        output rateSel, stepBtn, stepInstr, runReq, haltReq,
               bpEn, bpAddr, pcAddr, cycle,
        input  cpuEn, state, halted, bpHit
    );

    modport slave (
        input  rateSel, stepBtn, stepInstr, runReq, haltReq,
               bpEn, bpAddr, pcAddr, cycle,
        output cpuEn, state, halted, bpHit
    );

endinterface

// File: rtl/run_rate_gen.sv
// Prescaler for the slow/fast run rates; full rate ticks every clk and
// manual never ticks. The count restarts on a rate change or an explicit clear.
module run_rate_gen
    import cpu_run_pkg::*;
#(
    parameter int DIV_SLOW = 6000000,
    parameter int DIV_FAST = 600000
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [1:0] rateSel,
    input  logic       clear,
    output logic       tick
);

    localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int CNT_W   = $clog2(DIV_MAX);

    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(DIV_SLOW - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(DIV_FAST - 1);

    logic [CNT_W-1:0] preQ;
    logic [CNT_W-1:0] preEff;
    logic [CNT_W-1:0] preNext;
    logic [1:0]       rateQ;
    logic             rateChg;
    logic             counting;
    logic             atLast;

    // A clear takes effect in the same clk, so the first tick after it lands
    // exactly DIV clks later, counting the clearing clk as the first.
    always_comb begin
        rateChg  = (rateSel != rateQ);
        preEff   = (clear || rateChg) ? '0 : preQ;
        counting = 1'b0;
        atLast   = 1'b0;
        tick     = 1'b0;
        case (rateSel)
            RATE_SLOW: begin
                counting = 1'b1;
                atLast   = (preEff == SLOW_LAST);
                tick     = atLast;
            end
            RATE_FAST: begin
                counting = 1'b1;
                atLast   = (preEff == FAST_LAST);
                tick     = atLast;
            end
            RATE_FULL: tick = 1'b1;
            default:   tick = 1'b0;
        endcase
        if (!counting || atLast) begin
            preNext = '0;
        end else begin
            preNext = preEff + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            preQ  <= '0;
            rateQ <= RATE_MANUAL;
        end else begin
            preQ  <= preNext;
            rateQ <= rateSel;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step sequencer: turns run, halt, step and breakpoint events into a
// single registered clock enable (cpuEn) for the CPU core on the board clock.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int DIV_SLOW = 6000000,
    parameter int DIV_FAST = 600000,
    parameter int ADDR_W   = 12
) (
    input  logic           clk,
    input  logic           rstN,
    cpu_run_ctrl_if.slave  bus
);

    runState_t          stateQ;
    runState_t          stateNext;
    logic               cpuEnQ;
    logic               enNext;
    logic               skipBpQ;
    logic               skipNext;
    logic               bpHitQ;
    logic               bpHitNext;
    logic               stepPrevQ;
    logic               stepEdge;
    logic               rateClear;
    logic               tick;
    logic               boundary;
    logic               bpMatch;
    logic [PHASE_W-1:0] phaseNext;
    logic [ADDR_W-1:0]  pcAddr;
    logic [ADDR_W-1:0]  bpAddr;

    run_rate_gen #(
        .DIV_SLOW (DIV_SLOW),
        .DIV_FAST (DIV_FAST)
    ) rateGen (
        .clk     (clk),
        .rstN    (rstN),
        .rateSel (bus.rateSel),
        .clear   (rateClear),
        .tick    (tick)
    );

    assign pcAddr    = bus.pcAddr;
    assign bpAddr    = bus.bpAddr;
    assign phaseNext = nextPhase(bus.cycle, cpuEnQ);
    assign boundary  = (phaseNext == '0);
    assign bpMatch   = bus.bpEn && boundary && (pcAddr == bpAddr);
    assign stepEdge  = bus.stepBtn && !stepPrevQ;

    // Decisions made here land on cpuEn one clk later; boundary therefore
    // looks at the phase the next enable would execute, not the current one.
    always_comb begin
        stateNext = stateQ;
        enNext    = 1'b0;
        skipNext  = skipBpQ;
        bpHitNext = bpHitQ;
        rateClear = 1'b0;
        case (stateQ)
            ST_HALT: begin
                // A halt request has nothing to stop here but still outranks run/step.
                if (!bus.haltReq) begin
                    if (bus.runReq && (bus.rateSel != RATE_MANUAL)) begin
                        stateNext = ST_RUN;
                        skipNext  = 1'b1;
                        bpHitNext = 1'b0;
                        rateClear = 1'b1;
                    end else if (stepEdge) begin
                        enNext    = 1'b1;
                        bpHitNext = 1'b0;
                        if (bus.stepInstr) begin
                            stateNext = ST_STEP;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (bus.haltReq) begin
                    if (boundary) begin
                        stateNext = ST_HALT;
                    end else begin
                        stateNext = ST_DRAIN;
                        enNext    = tick;
                    end
                end else if (bpMatch && !skipBpQ) begin
                    stateNext = ST_HALT;
                    bpHitNext = 1'b1;
                end else begin
                    enNext = tick;
                    if (tick) begin
                        skipNext = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                if (boundary) begin
                    stateNext = ST_HALT;
                end else begin
                    enNext = tick;
                end
            end
            ST_STEP: begin
                // The first enable was issued on entry, so a boundary here ends the step.
                if (boundary) begin
                    stateNext = ST_HALT;
                end else begin
                    enNext = 1'b1;
                end
            end
            default: stateNext = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stateQ    <= ST_HALT;
            cpuEnQ    <= 1'b0;
            skipBpQ   <= 1'b0;
            bpHitQ    <= 1'b0;
            stepPrevQ <= 1'b0;
        end else begin
            stateQ    <= stateNext;
            cpuEnQ    <= enNext;
            skipBpQ   <= skipNext;
            bpHitQ    <= bpHitNext;
            stepPrevQ <= bus.stepBtn;
        end
    end

    assign bus.cpuEn  = cpuEnQ;
    assign bus.state  = stateQ;
    assign bus.halted = (stateQ == ST_HALT);
    assign bus.bpHit  = bpHitQ;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a small CPU model (phase counter and a
// four-instruction PC loop 0x010..0x013) driving cycle and pcAddr.
module tb_cpu_run_ctrl;
    import cpu_run_pkg::*;

    localparam int ADDR_W   = 12;
    localparam int DIV_SLOW = 10;
    localparam int DIV_FAST = 4;
    localparam int NVEC     = 35;

    localparam logic [ADDR_W-1:0] PC_FIRST = 12'h010;
    localparam logic [ADDR_W-1:0] PC_LAST  = 12'h013;
    localparam logic [ADDR_W-1:0] BP_ADDR  = 12'h012;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    cpu_run_ctrl #(
        .DIV_SLOW (DIV_SLOW),
        .DIV_FAST (DIV_FAST),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    // ---------------- CPU model ----------------
    logic [PHASE_W-1:0] cycleQ;
    logic [ADDR_W-1:0]  pcQ;
    logic [ADDR_W-1:0]  pcSucc;

    assign pcSucc = (pcQ == PC_LAST) ? PC_FIRST : pcQ + 1'b1;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cycleQ <= '0;
            pcQ    <= PC_FIRST;
        end else if (bus.cpuEn) begin
            cycleQ <= cycleQ + 1'b1;
            if (cycleQ == 3'd7) pcQ <= pcSucc;
        end
    end

    assign bus.cycle  = cycleQ;
    assign bus.pcAddr = (bus.cpuEn && (cycleQ == 3'd7)) ? pcSucc : pcQ;

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] rate;
        logic       btn;
        logic       instr;
        logic       run;
        logic       halt;
        logic [1:0] expState;
        logic       expEn;
        logic [2:0] expCycle;
    } vec_t;

    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic [1:0] rate, input logic btn, input logic instr,
                                input logic run, input logic halt, input logic [1:0] st,
                                input logic en, input logic [2:0] cyc);
        vec_t v;
        v.rate = rate; v.btn = btn; v.instr = instr; v.run = run; v.halt = halt;
        v.expState = st; v.expEn = en; v.expCycle = cyc;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    int vecCnt = 0;
    int errCnt = 0;
    logic [7:0] expQ[$];

    task automatic check(input string name, input int act, input int exp);
        vecCnt++;
        if (act != exp) begin
            errCnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulseRun();
        bus.runReq = 1'b1;
        @(negedge clk);
        bus.runReq = 1'b0;
    endtask

    task automatic pulseHalt();
        bus.haltReq = 1'b1;
        @(negedge clk);
        bus.haltReq = 1'b0;
    endtask

    task automatic waitPulse(input int maxClk, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cpuEn && n < maxClk);
    endtask

    task automatic waitHalted(input int maxClk, output int enCnt);
        int n;
        n     = 0;
        enCnt = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.cpuEn) enCnt++;
        end while (!bus.halted && n < maxClk);
    endtask

    initial begin
        int n;
        int enCnt;

        bus.rateSel   = RATE_MANUAL;
        bus.stepBtn   = 1'b0;
        bus.stepInstr = 1'b0;
        bus.runReq    = 1'b0;
        bus.haltReq   = 1'b0;
        bus.bpEn      = 1'b0;
        bus.bpAddr    = BP_ADDR;

        // Step, instruction step, ignored requests, run, drain, boundary halt.
        vecs[0]  = mk(RATE_MANUAL, 1, 0, 0, 0, 0, 1, 0);
        vecs[1]  = mk(RATE_MANUAL, 1, 0, 0, 0, 0, 0, 1);
        vecs[2]  = mk(RATE_MANUAL, 1, 0, 0, 0, 0, 0, 1);
        vecs[3]  = mk(RATE_MANUAL, 0, 0, 0, 0, 0, 0, 1);
        vecs[4]  = mk(RATE_MANUAL, 1, 1, 0, 0, 3, 1, 1);
        for (int k = 5; k <= 10; k++) vecs[k] = mk(RATE_MANUAL, 1, 1, 0, 0, 3, 1, 3'(k - 3));
        vecs[11] = mk(RATE_MANUAL, 1, 1, 0, 0, 0, 0, 0);
        vecs[12] = mk(RATE_MANUAL, 0, 0, 0, 0, 0, 0, 0);
        vecs[13] = mk(RATE_FULL,   0, 0, 1, 1, 0, 0, 0);
        vecs[14] = mk(RATE_MANUAL, 0, 0, 1, 0, 0, 0, 0);
        vecs[15] = mk(RATE_FULL,   0, 0, 1, 0, 1, 0, 0);
        vecs[16] = mk(RATE_FULL,   0, 0, 0, 0, 1, 1, 0);
        vecs[17] = mk(RATE_FULL,   0, 0, 0, 0, 1, 1, 1);
        vecs[18] = mk(RATE_FULL,   0, 0, 0, 0, 1, 1, 2);
        vecs[19] = mk(RATE_FULL,   0, 0, 0, 0, 1, 1, 3);
        vecs[20] = mk(RATE_FULL,   0, 0, 0, 1, 2, 1, 4);
        vecs[21] = mk(RATE_FULL,   0, 0, 0, 0, 2, 1, 5);
        vecs[22] = mk(RATE_FULL,   0, 0, 0, 0, 2, 1, 6);
        vecs[23] = mk(RATE_FULL,   0, 0, 0, 0, 2, 1, 7);
        vecs[24] = mk(RATE_FULL,   0, 0, 0, 0, 0, 0, 0);
        vecs[25] = mk(RATE_FULL,   0, 0, 1, 0, 1, 0, 0);
        for (int k = 26; k <= 33; k++) vecs[k] = mk(RATE_FULL, 0, 0, 0, 0, 1, 1, 3'(k - 26));
        vecs[34] = mk(RATE_FULL,   0, 0, 0, 1, 0, 0, 0);

        // Reset values.
        repeat (3) @(negedge clk);
        check("reset.state",  bus.state,  ST_HALT);
        check("reset.cpuEn",  bus.cpuEn,  0);
        check("reset.halted", bus.halted, 1);
        check("reset.bpHit",  bus.bpHit,  0);
        rstN = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            bus.rateSel   = vecs[i].rate;
            bus.stepBtn   = vecs[i].btn;
            bus.stepInstr = vecs[i].instr;
            bus.runReq    = vecs[i].run;
            bus.haltReq   = vecs[i].halt;
            @(negedge clk);
            check($sformatf("vec%0d.state", i),  bus.state,  vecs[i].expState);
            check($sformatf("vec%0d.cpuEn", i),  bus.cpuEn,  vecs[i].expEn);
            check($sformatf("vec%0d.cycle", i),  bus.cycle,  vecs[i].expCycle);
            check($sformatf("vec%0d.halted", i), bus.halted, (vecs[i].expState == 2'd0) ? 1 : 0);
            check($sformatf("vec%0d.bpHit", i),  bus.bpHit,  0);
        end
        bus.runReq  = 1'b0;
        bus.haltReq = 1'b0;

        // Slow rate period, then switch to fast mid-run.
        bus.rateSel = RATE_SLOW;
        pulseRun();
        check("slow.state", bus.state, ST_RUN);
        waitPulse(50, n);
        expQ = {8'd10, 8'd10, 8'd10, 8'd4, 8'd4};
        for (int g = 0; g < 5; g++) begin
            if (g == 3) bus.rateSel = RATE_FAST;
            waitPulse(50, n);
            check($sformatf("rate.gap%0d", g), n, int'(expQ.pop_front()));
        end

        bus.rateSel = RATE_FULL;
        pulseHalt();
        waitHalted(20, enCnt);
        check("slowHalt.halted", bus.halted, 1);
        check("slowHalt.cycle",  bus.cycle,  0);

        // Breakpoint stop, resume executes the stopped instruction, hit again.
        bus.bpEn = 1'b1;
        pulseRun();
        waitHalted(100, enCnt);
        check("bp1.halted", bus.halted, 1);
        check("bp1.bpHit",  bus.bpHit,  1);
        check("bp1.pcAddr", bus.pcAddr, BP_ADDR);
        check("bp1.cycle",  bus.cycle,  0);
        pulseRun();
        check("bpResume.bpHit", bus.bpHit, 0);
        check("bpResume.state", bus.state, ST_RUN);
        waitHalted(100, enCnt);
        check("bp2.enables", enCnt, 32);
        check("bp2.bpHit",   bus.bpHit, 1);
        check("bp2.pcAddr",  bus.pcAddr, BP_ADDR);
        check("bp2.cycle",   bus.cycle, 0);

        // A single-phase step clears the sticky hit.
        bus.bpEn      = 1'b0;
        bus.stepBtn   = 1'b1;
        bus.stepInstr = 1'b0;
        @(negedge clk);
        check("stepClr.bpHit", bus.bpHit, 0);
        check("stepClr.cpuEn", bus.cpuEn, 1);
        check("stepClr.state", bus.state, ST_HALT);
        bus.stepBtn = 1'b0;
        @(negedge clk);
        check("stepClr.cycle", bus.cycle, 1);

        // Asynchronous reset while draining.
        pulseRun();
        repeat (2) @(negedge clk);
        pulseHalt();
        check("drain.state", bus.state, ST_DRAIN);
        #2;
        rstN = 1'b0;
        #1;
        check("asyncRst.state",  bus.state,  ST_HALT);
        check("asyncRst.cpuEn",  bus.cpuEn,  0);
        check("asyncRst.halted", bus.halted, 1);
        check("asyncRst.bpHit",  bus.bpHit,  0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        check("postRst.cpuEn", bus.cpuEn, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run/halt/step sequencer for the CPU core: replaces direct clock muxing with a single-cycle clock-enable (cpuEn) on the board clock.
- Generates slow/fast/full-rate enables, single-clock and single-instruction steps, a halt request that drains to an instruction boundary, and a PC breakpoint.
- Sits between the button/switch front end (debounce, edge detect) and the CPU core plus its 8-phase cycle counter.

Parameters:
- DIV_SLOW, 6000000, clk periods per enable in slow rate.
- DIV_FAST, 600000, clk periods per enable in fast rate.
- ADDR_W, 12, PC/breakpoint width.

Ports:
- clk  in  1  board clock; the only clock.
- rstN  in  1  asynchronous, active-low reset.
- rateSel  in  2  00 manual, 01 slow, 10 fast, 11 full.
- stepBtn  in  1  debounced step level, active-high; rising edge detected internally.
- stepInstr  in  1  0 = step one clock phase, 1 = step to end of instruction.
- runReq  in  1  one-clk pulse: start free running.
- haltReq  in  1  one-clk pulse: stop at next instruction boundary.
- bpEn  in  1  breakpoint enable.
- bpAddr  in  ADDR_W  breakpoint address.
- pcAddr  in  ADDR_W  current CPU PC; valid for the next instruction whenever phaseNext==0.
- cycle  in  3  CPU phase counter (0..7); advances at the end of each clk in which cpuEn=1.
- cpuEn  out  1  registered clock enable, one clk per CPU phase.
- state  out  2  HALT=0, RUN=1, DRAIN=2, STEP=3.
- halted  out  1  state==HALT.
- bpHit  out  1  sticky; set on breakpoint stop, cleared by an accepted runReq or step.

Behaviour:
- Reset: state=HALT, cpuEn=0, halted=1, bpHit=0, prescaler=0, step-edge register=0, skipBp=0.
- phaseNext = cycle + cpuEn (3-bit wrap). This is the phase the next enable executes. Boundary = phaseNext==0.
- Rate tick: full = every clk. Slow/fast = prescaler reaches DIV-1, then wraps to 0. Prescaler clears on a rateSel change and on entering RUN. Manual = no tick.
- HALT:
  - cpuEn=0.
  - runReq with rateSel!=00 -> RUN, skipBp=1, bpHit=0.
  - runReq with rateSel==00 is ignored.
  - Step edge with stepInstr=0 -> exactly one cpuEn pulse on the next clk; state stays HALT; bpHit=0.
  - Step edge with stepInstr=1 -> STEP; bpHit=0.
- RUN:
  - cpuEn=tick.
  - Breakpoint: bpEn && boundary && pcAddr==bpAddr && !skipBp -> HALT with no enable issued, bpHit=1.
  - skipBp clears after the first enable issued in RUN, so resuming from a breakpoint executes that instruction.
  - rateSel==00 while in RUN: no enables; state stays RUN.
- DRAIN (entered on haltReq in RUN):
  - Enables continue at the current rate until boundary, then HALT with no further enable.
  - haltReq while boundary is already true -> HALT directly, zero extra enables.
  - Breakpoints are ignored in DRAIN.
- STEP: cpuEn=1 every clk, regardless of rateSel, until boundary (after at least one enable), then HALT. Breakpoints are ignored.
- Priority in one clk: reset > haltReq > breakpoint > runReq > step edge.
- haltReq in HALT/STEP, runReq in RUN/DRAIN/STEP, and step edges outside HALT are ignored.
- cpuEn never asserts in HALT except for the single-phase step pulse.
- Asynchronous reset mid-operation returns all outputs to reset values immediately.

Decomposition:
- Shared package cpu_run_pkg: state encoding (HALT/RUN/DRAIN/STEP), rate codes (RATE_MANUAL/SLOW/FAST/FULL), PHASE_W=3.
- One sub-module, run_rate_gen: prescaler plus tick generation. Inputs: rateSel, clear. Output: tick. Parameterised by DIV_SLOW and DIV_FAST.
- The FSM, edge detect, breakpoint compare and skipBp flag stay in cpu_run_ctrl.

Test Plan:
- Reset, rateSel=11, runReq -> state=RUN 1 clk later; cpuEn high every clk; cycle wraps 7->0 continuously.
- Bench DIV_SLOW=10, rateSel=01, run -> cpuEn pulses exactly every 10 clks. Switch to rateSel=10 (DIV_FAST=4) -> first pulse 4 clks after the change.
- Full rate, haltReq with cycle=3 -> exactly 5 more enables (phases 3..7), then state=HALT with cycle=0. haltReq with phaseNext=0 -> zero extra enables.
- bpEn=1, bpAddr=0x012, run at full rate -> HALT when PC=0x012 at phase 0 with no enable for it, bpHit=1. runReq -> instruction at 0x012 executes, bpHit=0; the next visit to 0x012 halts again.
- HALT at cycle=0: step edge with stepInstr=0 -> one cpuEn, cycle=1, state HALT. Step edge with stepInstr=1 -> 7 enables, cycle=0, state HALT. Holding stepBtn high -> no further steps.
- Same-clk haltReq+runReq in HALT -> stays HALT. Assert rstN low during DRAIN -> cpuEn=0, state=HALT, bpHit=0 asynchronously.
